sc_reg_target: RTL and testbench
================================

Name: sc_reg_target

Overview:
- Slow-control bus target that sits directly downstream of the slow-control controller.
- Consumes the sc_port/sc_addr/sc_data/sc_wr/sc_op/sc_frame request bus and answers each accepted operation with a one-cycle sc_ack, carrying sc_rply_data and sc_rply_error.
- Implements a bank of 32-bit configuration registers (read/write) and status registers (read-only) for one UDP slow-control port.
- Runs entirely in the 10 MHz slow-control domain.

Parameters:
- PORT, 16'd6007: sc_port value this target answers; any other port is ignored.
- NREGS, 16: number of 32-bit registers, addresses 0..NREGS-1; range 1..32.
- RO_MASK, 32'h0000_0000: bit i set makes register i read-only, sourced from status_in; only bits [NREGS-1:0] are used.

Ports:
- clk, input, 1: slow-control clock (10 MHz domain).
- rstn, input, 1: reset; asynchronous, active-low.
- sc_port, input, 16: destination UDP port of the current frame.
- sc_addr, input, 32: register address.
- sc_subaddr, input, 32: sub-address; ignored.
- sc_data, input, 32: write data.
- sc_wr, input, 1: 1 = write, 0 = read; qualified by sc_op.
- sc_op, input, 1: one-cycle operation strobe.
- sc_frame, input, 1: high for the whole request frame.
- sc_ack, output, 1: one-cycle reply strobe.
- sc_rply_data, output, 32: read data; valid with sc_ack.
- sc_rply_error, output, 32: error flags; valid with sc_ack.
- status_in, input, NREGS*32: read-only register sources; register i is bits [i*32+31:i*32].
- cfg_out, output, NREGS*32: current contents of the read/write registers.
- wr_pulse, output, NREGS: one-cycle pulse on bit i when register i is written.

Behaviour:
- Reset (rstn low, asynchronous): state IDLE; sc_ack=0; sc_rply_data=0; sc_rply_error=0; all cfg_out registers=0; wr_pulse=0.
- State machine, one-hot, with illegal-state recovery to IDLE:
  - IDLE: an operation is accepted when sc_op=1, sc_frame=1 and sc_port==PORT. On acceptance, latch addr, data and wr, then go to EXEC. Otherwise stay in IDLE.
  - EXEC (1 cycle):
    - If sc_frame=0: abort. Go to IDLE; no write, no ack, no wr_pulse.
    - Otherwise decode the latched address:
      - Write, address in range, register RW: update register; pulse wr_pulse[addr] this cycle; error=0.
      - Write to an RO register: no change; error bit1 set.
      - Read, RW register: data = register value.
      - Read, RO register: data = status_in slice, sampled this cycle.
      - Address >= NREGS (full 32-bit compare): error bit0 set; data=0; no write.
    - Register the reply, then go to ACK.
  - ACK (1 cycle): sc_ack=1 with the registered reply. If sc_frame=0 in this cycle, the ack is suppressed (sc_ack stays 0). Go to IDLE.
- Latency: sc_op sampled at edge N → sc_ack high during cycle N+2.
- Back-to-back: a new operation can be accepted in the IDLE cycle after ACK, giving a maximum throughput of one op per 3 cycles.
- sc_op seen in EXEC or ACK is ignored and is not queued; the controller must wait for sc_ack.
- sc_rply_data and sc_rply_error hold their last values outside ACK; consumers use them only when sc_ack=1.
- sc_rply_error bits: [0] address out of range, [1] write to read-only, [31:2] zero.
- Read and write use the same address decode; sc_subaddr has no effect.
- Reset mid-operation: immediate return to IDLE, registers cleared, no ack emitted.

Decomposition:
- Shared package (sc_bus_pkg): state encoding constants, error bit indices (ERR_ADDR=0, ERR_RO=1), default PORT value. These are shared with other slow-control targets and with the reply queue.
- No sub-module is needed. The register bank plus the 3-state FSM form a single module.

Test Plan:
- Write addr 3, data 0x12345678, port=PORT → sc_ack at N+2, err=0, cfg_out reg3=0x12345678, wr_pulse[3] for one cycle in EXEC. Then read addr 3 → data 0x12345678.
- RO_MASK bit5 set, status_in reg5=0xCAFE0001: read addr 5 → data 0xCAFE0001, err=0. Write addr 5 → err=0x2, reg5 unchanged, no wr_pulse.
- Read addr 16 (NREGS=16) and addr 0x80000003 → err=0x1, data=0, no state change.
- Op with sc_port=PORT+1 → no sc_ack, no register change. Op with sc_frame=0 → ignored.
- Drop sc_frame in the EXEC cycle of a write → no ack, register unchanged. Drop it in the ACK cycle → ack suppressed, write retained.
- Assert rstn low during EXEC → sc_ack stays 0, cfg_out all 0. The next op after reset completes normally with N+2 latency.

Source files
------------

// File: rtl/sc_bus_pkg.sv
// Shared slow-control bus definitions: FSM encoding, reply error bit indices
// and the default UDP port, common to every slow-control target.
package sc_bus_pkg;

  // One-hot so that any corrupted state is trivially recognisable.
  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_EXEC = 3'b010,
    ST_ACK  = 3'b100
  } sc_state_e;

  localparam int ERR_ADDR = 0;
  localparam int ERR_RO   = 1;

  localparam logic [15:0] SC_DEFAULT_PORT = 16'd6007;

endpackage

// File: rtl/sc_reg_target.sv
// Slow-control register target: a bank of 32-bit config (RW) and status (RO)
// registers behind a three-state accept/execute/acknowledge handshake.
module sc_reg_target
  import sc_bus_pkg::*;
#(
  parameter logic [15:0] PORT    = SC_DEFAULT_PORT,
  parameter int          NREGS   = 16,
  parameter logic [31:0] RO_MASK = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [15:0]           sc_port,
  input  logic [31:0]           sc_addr,
  input  logic [31:0]           sc_subaddr,
  input  logic [31:0]           sc_data,
  input  logic                  sc_wr,
  input  logic                  sc_op,
  input  logic                  sc_frame,
  output logic                  sc_ack,
  output logic [31:0]           sc_rply_data,
  output logic [31:0]           sc_rply_error,
  input  logic [NREGS*32-1:0]   status_in,
  output logic [NREGS*32-1:0]   cfg_out,
  output logic [NREGS-1:0]      wr_pulse
);

  localparam int IDXW = (NREGS > 1) ? $clog2(NREGS) : 1;

  sc_state_e       state_q, state_d;
  logic [31:0]     addr_q, data_q;
  logic            wr_q;
  logic [31:0]     cfg_q    [NREGS];
  logic [31:0]     status_w [NREGS];
  logic [IDXW-1:0] idx;
  logic            in_range, is_ro;
  logic            accept, exec_ok, do_write;
  logic [31:0]     rply_data_d, rply_err_d;
  logic            unused_subaddr;

  // The sub-address is part of the bus but carries no meaning for this target.
  assign unused_subaddr = ^sc_subaddr;

  for (genvar i = 0; i < NREGS; i++) begin : g_slice
    assign cfg_out[i*32 +: 32] = cfg_q[i];
    assign status_w[i]         = status_in[i*32 +: 32];
  end

  // Full 32-bit compare, so high address bits never alias onto a register.
  assign idx      = addr_q[IDXW-1:0];
  assign in_range = (addr_q < 32'(NREGS));
  assign is_ro    = RO_MASK[idx];

  // NOTE: every signal driven in always_comb gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d  = ST_IDLE;
    accept   = 1'b0;
    exec_ok  = 1'b0;
    do_write = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (sc_op && sc_frame && (sc_port == PORT)) begin
          accept  = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (sc_frame) begin
          exec_ok  = 1'b1;
          do_write = wr_q && in_range && !is_ro;
          state_d  = ST_ACK;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rply_data_d = '0;
    rply_err_d  = '0;
    if (!in_range) begin
      rply_err_d[ERR_ADDR] = 1'b1;
    end else if (wr_q) begin
      if (is_ro) rply_err_d[ERR_RO] = 1'b1;
    end else if (is_ro) begin
      rply_data_d = status_w[idx];
    end else begin
      rply_data_d = cfg_q[idx];
    end
  end

  always_comb begin
    wr_pulse = '0;
    if (do_write) wr_pulse[idx] = 1'b1;
  end

  // A frame dropped during ACK withdraws the acknowledge immediately.
  assign sc_ack = (state_q == ST_ACK) && sc_frame;

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      data_q        <= '0;
      wr_q          <= 1'b0;
      sc_rply_data  <= '0;
      sc_rply_error <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= sc_addr;
        data_q <= sc_data;
        wr_q   <= sc_wr;
      end
      if (exec_ok) begin
        sc_rply_data  <= rply_data_d;
        sc_rply_error <= rply_err_d;
      end
    end
  end

  // NOTE: the register bank is reset explicitly because downstream logic relies
  // on cfg_out reading zero after reset; this is not a RAM and must not map to one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREGS; i++) cfg_q[i] <= '0;
    end else if (do_write) begin
      cfg_q[idx] <= data_q;
    end
  end

endmodule

// File: tb/tb_sc_reg_target.sv
// Directed bench for sc_reg_target: one task per scenario, expected values
// hand-computed and tracked in a small register model.
module tb_sc_reg_target;

  localparam logic [15:0] PORT    = 16'd6007;
  localparam int          NREGS   = 16;
  localparam logic [31:0] RO_MASK = 32'h0000_0020;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic [15:0]         sc_port = '0;
  logic [31:0]         sc_addr = '0, sc_subaddr = '0, sc_data = '0;
  logic                sc_wr = 1'b0, sc_op = 1'b0, sc_frame = 1'b0;
  logic                sc_ack;
  logic [31:0]         sc_rply_data, sc_rply_error;
  logic [NREGS*32-1:0] status_in;
  logic [NREGS*32-1:0] cfg_out;
  logic [NREGS-1:0]    wr_pulse;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] model [NREGS];

  sc_reg_target #(.PORT(PORT), .NREGS(NREGS), .RO_MASK(RO_MASK)) dut (
    .clk(clk), .rstn(rstn), .sc_port(sc_port), .sc_addr(sc_addr),
    .sc_subaddr(sc_subaddr), .sc_data(sc_data), .sc_wr(sc_wr), .sc_op(sc_op),
    .sc_frame(sc_frame), .sc_ack(sc_ack), .sc_rply_data(sc_rply_data),
    .sc_rply_error(sc_rply_error), .status_in(status_in), .cfg_out(cfg_out),
    .wr_pulse(wr_pulse)
  );

  always #50 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [NREGS*32-1:0] model_flat();
    logic [NREGS*32-1:0] v;
    for (int i = 0; i < NREGS; i++) v[i*32 +: 32] = model[i];
    return v;
  endfunction

  // Called at a negedge; issues one op and returns at the negedge of the
  // following IDLE cycle. acks = {exec cycle, ack cycle, idle cycle}.
  task automatic do_op(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [15:0] port, input logic f_op, input logic f_exec,
                       input logic f_ack, output logic [2:0] acks,
                       output logic [NREGS-1:0] pulse, output logic [31:0] rdata,
                       output logic [31:0] rerr);
    sc_port = port; sc_addr = addr; sc_data = data; sc_wr = wr;
    sc_subaddr = 32'hFFFF_FFFF; sc_op = 1'b1; sc_frame = f_op;
    @(negedge clk);
    sc_op = 1'b0; sc_frame = f_exec; #1;
    acks[2] = sc_ack; pulse = wr_pulse;
    @(negedge clk);
    sc_frame = f_ack; #1;
    acks[1] = sc_ack; rdata = sc_rply_data; rerr = sc_rply_error;
    @(negedge clk);
    sc_frame = 1'b0; #1;
    acks[0] = sc_ack;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    tests_run++; if (cfg_out !== '0) begin tests_failed++; $display("FAIL reset_cfg: got %h expected 0", cfg_out); end
    tests_run++; if (sc_ack !== 1'b0) begin tests_failed++; $display("FAIL reset_ack: got %b expected 0", sc_ack); end
    tests_run++; if (sc_rply_data !== 32'h0 || sc_rply_error !== 32'h0) begin tests_failed++; $display("FAIL reset_rply: got %h/%h expected 0/0", sc_rply_data, sc_rply_error); end
    tests_run++; if (wr_pulse !== '0) begin tests_failed++; $display("FAIL reset_pulse: got %h expected 0", wr_pulse); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    logic [2:0] a; logic [NREGS-1:0] p; logic [31:0] d, e;
    do_op(1'b1, 32'd3, 32'h1234_5678, PORT, 1'b1, 1'b1, 1'b1, a, p, d, e);
    model[3] = 32'h1234_5678;
    tests_run++; if (a !== 3'b010) begin tests_failed++; $display("FAIL wr3_latency: got %b expected 010", a); end
    tests_run++; if (e !== 32'h0) begin tests_failed++; $display("FAIL wr3_err: got %h expected 0", e); end
    tests_run++; if (p !== 16'h0008) begin tests_failed++; $display("FAIL wr3_pulse: got %h expected 0008", p); end
    tests_run++; if (cfg_out !== model_flat()) begin tests_failed++; $display("FAIL wr3_cfg: got %h expected %h", cfg_out, model_flat()); end
    do_op(1'b0, 32'd3, 32'h0, PORT, 1'b1, 1'b1, 1'b1, a, p, d, e);
    tests_run++; if (a !== 3'b010 || d !== 32'h1234_5678 || e !== 32'h0) begin tests_failed++; $display("FAIL rd3: got ack %b data %h err %h expected 010 12345678 0", a, d, e); end
    tests_run++; if (p !== '0) begin tests_failed++; $display("FAIL rd3_pulse: got %h expected 0", p); end
    do_op(1'b1, 32'd15, 32'hA5A5_5A5A, PORT, 1'b1, 1'b1, 1'b1, a, p, d, e);
    model[15] = 32'hA5A5_5A5A;
    tests_run++; if (a !== 3'b010 || p !== 16'h8000 || e !== 32'h0) begin tests_failed++; $display("FAIL wr15: got ack %b pulse %h err %h expected 010 8000 0", a, p, e); end
    do_op(1'b0, 32'd0, 32'h0, PORT, 1'b1, 1'b1, 1'b1, a, p, d, e);
    tests_run++; if (d !== 32'h0 || e !== 32'h0) begin tests_failed++; $display("FAIL rd0: got %h/%h expected 0/0", d, e); end
  endtask

  task automatic test_read_only();
    logic [2:0] a; logic [NREGS-1:0] p; logic [31:0] d, e;
    do_op(1'b0, 32'd5, 32'h0, PORT, 1'b1, 1'b1, 1'b1, a, p, d, e);
    tests_run++; if (a !== 3'b010 || d !== 32'hCAFE_0001 || e !== 32'h0) begin tests_failed++; $display("FAIL rd5: got ack %b data %h err %h expected 010 cafe0001 0", a, d, e); end
    do_op(1'b1, 32'd5, 32'hDEAD_BEEF, PORT, 1'b1, 1'b1, 1'b1, a, p, d, e);
    tests_run++; if (a !== 3'b010 || e !== 32'h2) begin tests_failed++; $display("FAIL wr5_err: got ack %b err %h expected 010 2", a, e); end
    tests_run++; if (p !== '0 || cfg_out !== model_flat()) begin tests_failed++; $display("FAIL wr5_nochange: pulse %h cfg %h expected 0 %h", p, cfg_out, model_flat()); end
    status_in[5*32 +: 32] = 32'hCAFE_0002;
    do_op(1'b0, 32'd5, 32'h0, PORT, 1'b1, 1'b1, 1'b1, a, p, d, e);
    tests_run++; if (d !== 32'hCAFE_0002) begin tests_failed++; $display("FAIL rd5_live: got %h expected cafe0002", d); end
  endtask

  task automatic test_out_of_range();
    logic [2:0] a; logic [NREGS-1:0] p; logic [31:0] d, e;
    do_op(1'b0, 32'd16, 32'h0, PORT, 1'b1, 1'b1, 1'b1, a, p, d, e);
    tests_run++; if (a !== 3'b010 || d !== 32'h0 || e !== 32'h1) begin tests_failed++; $display("FAIL rd16: got ack %b data %h err %h expected 010 0 1", a, d, e); end
    do_op(1'b0, 32'h8000_0003, 32'h0, PORT, 1'b1, 1'b1, 1'b1, a, p, d, e);
    tests_run++; if (d !== 32'h0 || e !== 32'h1) begin tests_failed++; $display("FAIL rd_hi_addr: got data %h err %h expected 0 1", d, e); end
    do_op(1'b1, 32'h8000_0003, 32'h5555_5555, PORT, 1'b1, 1'b1, 1'b1, a, p, d, e);
    tests_run++; if (e !== 32'h1 || p !== '0) begin tests_failed++; $display("FAIL wr_hi_addr: got err %h pulse %h expected 1 0", e, p); end
    tests_run++; if (cfg_out !== model_flat()) begin tests_failed++; $display("FAIL oor_cfg: got %h expected %h", cfg_out, model_flat()); end
  endtask

  task automatic test_ignored();
    logic [2:0] a; logic [NREGS-1:0] p; logic [31:0] d, e;
    do_op(1'b1, 32'd4, 32'h4444_4444, PORT + 16'd1, 1'b1, 1'b1, 1'b1, a, p, d, e);
    tests_run++; if (a !== 3'b000 || p !== '0) begin tests_failed++; $display("FAIL wrong_port: got ack %b pulse %h expected 000 0", a, p); end
    do_op(1'b1, 32'd4, 32'h4444_4444, PORT, 1'b0, 1'b1, 1'b1, a, p, d, e);
    tests_run++; if (a !== 3'b000 || p !== '0) begin tests_failed++; $display("FAIL no_frame: got ack %b pulse %h expected 000 0", a, p); end
    tests_run++; if (cfg_out !== model_flat()) begin tests_failed++; $display("FAIL ignored_cfg: got %h expected %h", cfg_out, model_flat()); end
  endtask

  task automatic test_frame_drop();
    logic [2:0] a; logic [NREGS-1:0] p; logic [31:0] d, e;
    do_op(1'b1, 32'd6, 32'h6666_0000, PORT, 1'b1, 1'b0, 1'b1, a, p, d, e);
    tests_run++; if (a !== 3'b000 || p !== '0 || cfg_out !== model_flat()) begin tests_failed++; $display("FAIL drop_exec: ack %b pulse %h cfg %h expected 000 0 %h", a, p, cfg_out, model_flat()); end
    do_op(1'b1, 32'd6, 32'h6666_1111, PORT, 1'b1, 1'b1, 1'b0, a, p, d, e);
    model[6] = 32'h6666_1111;
    tests_run++; if (a !== 3'b000 || p !== 16'h0040) begin tests_failed++; $display("FAIL drop_ack: got ack %b pulse %h expected 000 0040", a, p); end
    tests_run++; if (cfg_out !== model_flat()) begin tests_failed++; $display("FAIL drop_ack_cfg: got %h expected %h", cfg_out, model_flat()); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] a; logic [NREGS-1:0] p; logic [31:0] d, e;
    int acks, pulses;
    do_op(1'b1, 32'd1, 32'h0B0B_0001, PORT, 1'b1, 1'b1, 1'b1, a, p, d, e);
    model[1] = 32'h0B0B_0001;
    do_op(1'b0, 32'd1, 32'h0, PORT, 1'b1, 1'b1, 1'b1, a, p, d, e);
    tests_run++; if (a !== 3'b010 || d !== 32'h0B0B_0001) begin tests_failed++; $display("FAIL b2b_read: got ack %b data %h expected 010 0b0b0001", a, d); end
    // sc_op held through EXEC and ACK must yield exactly one operation.
    acks = 0; pulses = 0;
    sc_port = PORT; sc_addr = 32'd8; sc_data = 32'h0808_0808; sc_wr = 1'b1;
    sc_op = 1'b1; sc_frame = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      acks += int'(sc_ack); pulses += int'(wr_pulse[8]);
    end
    sc_op = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      acks += int'(sc_ack); pulses += int'(wr_pulse[8]);
    end
    sc_frame = 1'b0;
    model[8] = 32'h0808_0808;
    tests_run++; if (acks != 1 || pulses != 1) begin tests_failed++; $display("FAIL op_not_queued: got acks %0d pulses %0d expected 1 1", acks, pulses); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    logic [2:0] a; logic [NREGS-1:0] p; logic [31:0] d, e;
    sc_port = PORT; sc_addr = 32'd7; sc_data = 32'h7777_7777; sc_wr = 1'b1;
    sc_op = 1'b1; sc_frame = 1'b1;
    @(negedge clk);
    sc_op = 1'b0; rstn = 1'b0; #1;
    for (int i = 0; i < NREGS; i++) model[i] = '0;
    tests_run++; if (sc_ack !== 1'b0 || cfg_out !== '0 || wr_pulse !== '0) begin tests_failed++; $display("FAIL rst_exec: ack %b cfg %h pulse %h expected 0 0 0", sc_ack, cfg_out, wr_pulse); end
    @(negedge clk); #1;
    tests_run++; if (sc_ack !== 1'b0) begin tests_failed++; $display("FAIL rst_no_ack: got %b expected 0", sc_ack); end
    rstn = 1'b1; sc_frame = 1'b0;
    @(negedge clk);
    do_op(1'b1, 32'd2, 32'h2222_2222, PORT, 1'b1, 1'b1, 1'b1, a, p, d, e);
    model[2] = 32'h2222_2222;
    tests_run++; if (a !== 3'b010 || p !== 16'h0004 || cfg_out !== model_flat()) begin tests_failed++; $display("FAIL post_rst_op: ack %b pulse %h cfg %h expected 010 0004 %h", a, p, cfg_out, model_flat()); end
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) begin
      status_in[i*32 +: 32] = 32'h5000_0000 + 32'(i);
      model[i] = '0;
    end
    status_in[5*32 +: 32] = 32'hCAFE_0001;
    test_reset();
    test_write_read();
    test_read_only();
    test_out_of_range();
    test_ignored();
    test_frame_drop();
    test_back_to_back();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
